// File: rtl/led_driver2_if.sv
// led_driver2_if -- frame request / serial strip bundle for led_driver2.
// Signals: start, rgb[BIN_QTY][24], LEDCounts[BIN_QTY][$clog2(LEDS)] from the requester;
//          dOut, clkOut, done back from the driver.
// master = requester side, slave = led_driver2 side.
interface led_driver2_if #(
   parameter int LEDS    = 50,
   parameter int BIN_QTY = 12
);
   logic                                 start;
   logic [BIN_QTY-1:0][23:0]             rgb;
   logic [BIN_QTY-1:0][$clog2(LEDS)-1:0] LEDCounts;
   logic                                 dOut;
   logic                                 clkOut;
   logic                                 done;

   modport master (
      output start, rgb, LEDCounts,
      input  dOut, clkOut, done
   );

   modport slave (
      input  start, rgb, LEDCounts,
      output dOut, clkOut, done
   );
endinterface

// File: rtl/led_driver2.sv
// led_driver2 -- serial LED strip frame generator: 32 zero bits, LEDS words of {8'hFF,B,G,R}, colours by bin.
// Latency: frame starts the cycle after start is seen in IDLE/DONE; each bit takes 2*FREQ_DIV clk cycles.
// Backpressure: none; start is a level request sampled only between frames, inputs latched at frame start.
// Ports: clk, rst (synchronous, active-high); bus (led_driver2_if.slave) carries start/rgb/LEDCounts in,
//        dOut/clkOut/done out.
// Option: define LEDDRIVER2_END_FRAME_EN to append 32*ceil(LEDS/64) one-bits after the LED words.
module led_driver2 #(
   parameter int LEDS     = 50,
   parameter int FREQ     = 12_500_000,
   parameter int FREQ_DIV = 5,
   parameter int BIN_QTY  = 12
) (
   input  logic         clk,
   input  logic         rst,
   led_driver2_if.slave bus
);

   localparam int CW        = $clog2(LEDS);
   localparam int WCW       = $clog2(LEDS + 1);
   localparam int DW        = (FREQ_DIV > 1) ? $clog2(FREQ_DIV) : 1;
   localparam int SW        = CW + $clog2(BIN_QTY) + 1;
   localparam int END_WORDS = (LEDS + 63) / 64;

   // FREQ is informational only; no timing is derived from it.
   if (FREQ < 1) begin : g_freq_info
   end

   typedef enum logic [2:0] {
      IDLE,
      START_FRAME,
      LED_FRAME,
      END_FRAME,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   // Latched frame configuration
   logic [BIN_QTY-1:0][23:0]   rgb_q;
   logic [BIN_QTY-1:0][CW-1:0] cnt_q;

   // Serial timing counters
   logic [DW-1:0]  div_cnt;   // clk cycles within the current half-period
   logic           phase;     // 0 = clkOut low half, 1 = clkOut high half
   logic [4:0]     bit_idx;   // bit position within the current word
   logic [WCW-1:0] word_cnt;  // word index within the current section
   logic [31:0]    sh;        // outgoing word, MSB on dOut

   logic           in_frame;
   logic           half_end;
   logic           bit_end;
   logic           word_end;
   logic           last_word;
   logic           frame_go;
   logic [WCW-1:0] load_idx;
   logic [31:0]    led_word;
   logic [31:0]    next_word;

   assign in_frame = (state == START_FRAME) || (state == LED_FRAME) || (state == END_FRAME);
   assign half_end = (div_cnt == DW'(FREQ_DIV - 1));
   assign bit_end  = in_frame && phase && half_end;
   assign word_end = bit_end && (bit_idx == 5'd31);
   // DONE accepts a new request directly so continuous refresh shows done for a single cycle.
   assign frame_go = ((state == IDLE) || (state == DONE)) && bus.start;

   // Last word of the section currently being shifted out
   always_comb begin
      last_word = 1'b0;
      case (state)
         START_FRAME: last_word = 1'b1;
         LED_FRAME:   last_word = (word_cnt == WCW'(LEDS - 1));
         END_FRAME:   last_word = (word_cnt == WCW'(END_WORDS - 1));
         default:     last_word = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = START_FRAME;
            end
         end
         START_FRAME: begin
            if (word_end) begin
               state_nxt = LED_FRAME;
            end
         end
         LED_FRAME: begin
            if (word_end && last_word) begin
`ifdef LEDDRIVER2_END_FRAME_EN
               state_nxt = END_FRAME;
`else
               state_nxt = DONE;
`endif
            end
         end
         END_FRAME: begin
            if (word_end && last_word) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = bus.start ? START_FRAME : IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (decoded from registers only)
   // ------------------------------------------------------------------
   always_comb begin
      bus.done   = (state == IDLE) || (state == DONE);
      bus.clkOut = in_frame && phase;
      bus.dOut   = in_frame && sh[31];
   end

   // ------------------------------------------------------------------
   // Colour lookup for the next LED word. The LED index is compared
   // against running bin totals; a zero-count bin adds nothing to the
   // total and so can never match, which skips it. Indices beyond the
   // sum of all counts fall through to the unlit word, and the frame
   // length is bounded by LEDS, which truncates an oversubscribed sum.
   // ------------------------------------------------------------------
   always_comb begin : p_led_lookup
      logic [SW-1:0] acc;
      logic          hit;
      logic [23:0]   col;
      acc      = '0;
      hit      = 1'b0;
      col      = '0;
      load_idx = (state == LED_FRAME) ? (word_cnt + WCW'(1)) : '0;
      for (int i = 0; i < BIN_QTY; i++) begin
         if (!hit && (SW'(load_idx) < (acc + SW'(cnt_q[i])))) begin
            hit = 1'b1;
            col = rgb_q[i];
         end
         acc = acc + SW'(cnt_q[i]);
      end
      // Strip word layout: 3'b111, 5-bit global brightness (max), B, G, R
      led_word = hit ? {8'hFF, col[7:0], col[15:8], col[23:16]} : 32'hE000_0000;
   end

   // Word loaded into the shifter when the current word finishes
   always_comb begin
      next_word = 32'h0;
      case (state)
         START_FRAME: next_word = led_word;
         LED_FRAME: begin
            if (!last_word) begin
               next_word = led_word;
            end
`ifdef LEDDRIVER2_END_FRAME_EN
            else begin
               next_word = 32'hFFFF_FFFF;
            end
`endif
         end
         END_FRAME: begin
            if (!last_word) begin
               next_word = 32'hFFFF_FFFF;
            end
         end
         default: next_word = 32'h0;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: latching, bit timing and shift register.
   // The shifter only advances at the end of a high half, so dOut moves
   // exactly when clkOut drops and is stable across the rising edge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q    <= '0;
         cnt_q    <= '0;
         div_cnt  <= '0;
         phase    <= 1'b0;
         bit_idx  <= '0;
         word_cnt <= '0;
         sh       <= '0;
      end else if (frame_go) begin
         rgb_q    <= bus.rgb;
         cnt_q    <= bus.LEDCounts;
         div_cnt  <= '0;
         phase    <= 1'b0;
         bit_idx  <= '0;
         word_cnt <= '0;
         sh       <= '0;   // start frame is all zeros
      end else if (in_frame) begin
         if (half_end) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase) begin
               bit_idx <= bit_idx + 5'd1;
               if (bit_idx == 5'd31) begin
                  word_cnt <= last_word ? '0 : (word_cnt + WCW'(1));
                  sh       <= next_word;
               end else begin
                  sh <= {sh[30:0], 1'b0};
               end
            end
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_led_driver2.sv
// tb_led_driver2 -- randomized/directed bench for led_driver2 with a word-level reference model.
// The model expands bins into LED words directly; captured strip bits are compared word by word.
module tb_led_driver2;

   localparam int LEDS     = 50;
   localparam int FREQ_DIV = 5;
   localparam int BIN_QTY  = 12;
   localparam int CW       = $clog2(LEDS);
`ifdef LEDDRIVER2_END_FRAME_EN
   localparam int END_BITS = 32 * ((LEDS + 63) / 64);
`else
   localparam int END_BITS = 0;
`endif
   localparam int FRAME_BITS = 32 + 32 * LEDS + END_BITS;
   localparam int FRAME_CYC  = FRAME_BITS * 2 * FREQ_DIV;

   typedef logic [BIN_QTY-1:0][23:0]   rgb_t;
   typedef logic [BIN_QTY-1:0][CW-1:0] cnt_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic        bits[$];
   logic [31:0] exp_words[$];
   rgb_t        nxt_rgb;
   cnt_t        nxt_cnt;

   int   hi_bad   = 0;
   int   dout_bad = 0;
   int   idle_bad = 0;
   int   hi_run   = 0;
   logic prev_clk_out = 1'b0;
   logic prev_dout    = 1'b0;
   logic prev_rst     = 1'b1;

   always #5 clk = ~clk;

   led_driver2_if #(.LEDS(LEDS), .BIN_QTY(BIN_QTY)) bus ();

   led_driver2 #(
      .LEDS    (LEDS),
      .FREQ    (12_500_000),
      .FREQ_DIV(FREQ_DIV),
      .BIN_QTY (BIN_QTY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Strip-side monitor: capture dOut on clkOut rising edges, watch phase widths and idle levels
   always @(negedge clk) begin
      if (bus.clkOut === 1'b1 && prev_clk_out === 1'b0) bits.push_back(bus.dOut);
      if (bus.clkOut === 1'b1) begin
         hi_run++;
      end else begin
         if (prev_clk_out === 1'b1 && prev_rst !== 1'b1 && hi_run != FREQ_DIV) hi_bad++;
         hi_run = 0;
      end
      if (bus.clkOut === 1'b1 && bus.dOut !== prev_dout) dout_bad++;
      if (bus.done === 1'b1 && (bus.clkOut !== 1'b0 || bus.dOut !== 1'b0)) idle_bad++;
      prev_clk_out = bus.clkOut;
      prev_dout    = bus.dOut;
      prev_rst     = rst;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: bins in order, count[b] copies of colour b, cap at LEDS, pad unlit
   task automatic model_frame(input rgb_t r, input cnt_t c);
      exp_words.delete();
      for (int b = 0; b < BIN_QTY; b++) begin
         for (int k = 0; k < int'(c[b]); k++) begin
            if (exp_words.size() < LEDS)
               exp_words.push_back({8'hFF, r[b][7:0], r[b][15:8], r[b][23:16]});
         end
      end
      while (exp_words.size() < LEDS) exp_words.push_back(32'hE000_0000);
   endtask

   // Wait for done low, record the frame, optionally change inputs a third of the way in
   task automatic capture_frame(input bit change_mid, output int low);
      int n;
      n = 0;
      while (bus.done !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("frame_start_wait", 64'(n < 100), 64'd1);
      bits.delete();
      low = 0;
      while (bus.done === 1'b0 && low < FRAME_CYC + 1000) begin
         @(negedge clk);
         low++;
         if (change_mid && low == FRAME_CYC / 3) begin
            bus.rgb       = nxt_rgb;
            bus.LEDCounts = nxt_cnt;
         end
      end
   endtask

   task automatic check_frame(input string tag, input int low);
      logic [31:0] w;
      chk({tag, "_done_low_cycles"}, 64'(low), 64'(FRAME_CYC));
      chk({tag, "_bit_count"}, 64'(bits.size()), 64'(FRAME_BITS));
      if (bits.size() == FRAME_BITS) begin
         for (int i = 0; i < FRAME_BITS / 32; i++) begin
            w = '0;
            for (int j = 0; j < 32; j++) w = {w[30:0], bits[32 * i + j]};
            if (i == 0)
               chk({tag, "_start_word"}, 64'(w), 64'd0);
            else if (i <= LEDS)
               chk($sformatf("%s_led%0d", tag, i - 1), 64'(w), 64'(exp_words[i - 1]));
            else
               chk($sformatf("%s_end%0d", tag, i - 1 - LEDS), 64'(w), 64'hFFFF_FFFF);
         end
      end
   endtask

   initial begin
      int          low;
      int          n;
      logic [31:0] w;
      rgb_t        r_bins, r_rand, r_tr;
      cnt_t        c_bins, c_rand, c_tr;

      // Configurations
      r_bins    = '0;
      c_bins    = '0;
      r_bins[0] = 24'hFFFFFF;
      r_bins[1] = 24'hF0F0F0;
      r_bins[2] = 24'hAAAAAA;
      c_bins[0] = CW'(10);
      c_bins[1] = CW'(10);
      c_bins[2] = CW'(10);
      for (int b = 0; b < BIN_QTY; b++) begin
         r_rand[b] = 24'($urandom);
         c_rand[b] = CW'($urandom_range(0, 9));
         r_tr[b]   = 24'($urandom);
      end
      c_rand[1] = '0;
      c_tr      = '0;
      c_tr[0]   = CW'(40);
      c_tr[1]   = CW'(40);

      // Reset held 10 cycles with start asserted
      rst           = 1'b1;
      bus.start     = 1'b1;
      bus.rgb       = r_bins;
      bus.LEDCounts = c_bins;
      repeat (10) begin
         @(negedge clk);
         chk("reset_outputs", 64'({bus.done, bus.clkOut, bus.dOut}), 64'(3'b100));
      end
      #1 rst = 1'b0;
      @(negedge clk);
      chk("done_fall_after_reset", 64'(bus.done), 64'd0);

      // Frame 1: bin colours
      model_frame(r_bins, c_bins);
      capture_frame(1'b0, low);
      check_frame("bins", low);
      @(negedge clk);
      chk("done_one_cycle_f1", 64'(bus.done), 64'd0);

      // Frame 2: inputs change mid-frame, frame stays on the latched bins
      nxt_rgb = r_rand;
      nxt_cnt = c_rand;
      capture_frame(1'b1, low);
      check_frame("latch_cur", low);
      @(negedge clk);
      chk("done_one_cycle_f2", 64'(bus.done), 64'd0);

      // Frame 3: random configuration picked up at the frame boundary
      model_frame(r_rand, c_rand);
      nxt_rgb = r_tr;
      nxt_cnt = c_tr;
      capture_frame(1'b1, low);
      check_frame("latch_next", low);
      @(negedge clk);
      chk("done_one_cycle_f3", 64'(bus.done), 64'd0);

      // Frame 4: counts sum past LEDS, truncated
      model_frame(r_tr, c_tr);
      capture_frame(1'b0, low);
      check_frame("trunc", low);
      @(negedge clk);
      chk("done_one_cycle_f4", 64'(bus.done), 64'd0);

      // Frame 5: reset inside the LED section
      repeat (600) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midreset_idle", 64'({bus.done, bus.clkOut, bus.dOut}), 64'(3'b100));
      #1 rst = 1'b0;
      bits.delete();
      n = 0;
      while (bits.size() < 64 && n < 64 * 2 * FREQ_DIV + 100) begin
         @(negedge clk);
         n++;
      end
      chk("midreset_restart_bits", 64'(bits.size() >= 64), 64'd1);
      if (bits.size() >= 64) begin
         w = '0;
         for (int j = 0; j < 32; j++) w = {w[30:0], bits[j]};
         chk("midreset_start_word", 64'(w), 64'd0);
         w = '0;
         for (int j = 32; j < 64; j++) w = {w[30:0], bits[j]};
         chk("midreset_led0", 64'(w), 64'(exp_words[0]));
      end

      // Idle with start low: no strip activity
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      bits.delete();
      repeat (100) @(negedge clk);
      chk("idle_no_clkout", 64'(bits.size()), 64'd0);
      chk("idle_done", 64'(bus.done), 64'd1);

      chk("high_phase_width", 64'(hi_bad), 64'd0);
      chk("dout_stable_high", 64'(dout_bad), 64'd0);
      chk("idle_levels", 64'(idle_bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
